// File: rtl/bfp_pkg.sv
// bfp_pkg -- shared definitions for the block-floating-point scaler.
//   state_t     : scaler FSM states (IDLE / RUN / DRAIN)
//   GUARD_BITS  : headroom kept above the largest sample (target width = DW - GUARD_BITS)
//   calc_shift  : converts a measured max bit width into a right-shift amount
package bfp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int GUARD_BITS = 1;

  // Target width TGT = dw - GUARD_BITS. Anything wider than TGT is shifted
  // down to TGT bits; the shift never exceeds dw-1 (which leaves only the sign).
  function automatic int calc_shift(input int max_bw, input int dw);
    int tgt;
    int diff;
    tgt = dw - GUARD_BITS;
    if (max_bw > tgt) begin
      diff = max_bw - tgt;
      return (diff > dw - 1) ? dw - 1 : diff;
    end
    return 0;
  endfunction

endpackage

// File: rtl/bfp_round_shift.sv
// bfp_round_shift -- arithmetic right shift of one signed sample component.
// Build option: BFP_ROUND_EN defined -> round-half-up (adds 2**(shift-1) first);
//               undefined            -> plain truncation toward -inf, no adder.
// Ports:
//   din   in  DW  signed input component
//   shift in  SW  shift amount (caller guarantees shift <= DW-1)
//   dout  out DW  shifted component
module bfp_round_shift #(
  parameter int DW = 16,
  parameter int SW = 5
) (
  input  logic [DW-1:0] din,
  input  logic [SW-1:0] shift,
  output logic [DW-1:0] dout
);

  // One extra bit so the rounding bias cannot overflow (32767 + 2**14 fits).
  logic signed [DW:0] ext;
  logic signed [DW:0] biased;
  logic signed [DW:0] shifted;

  assign ext = $signed({din[DW-1], din});

`ifdef BFP_ROUND_EN
  logic signed [DW:0] half;

  always_comb begin
    half = '0;
    if (shift != '0) begin
      half = $signed((DW+1)'(1) << (shift - SW'(1)));
    end
  end

  assign biased = ext + half;
`else
  assign biased = ext;
`endif

  assign shifted = biased >>> shift;

  // With shift >= 1 whenever a bias is added, the result always fits DW bits.
  assign dout = shifted[DW-1:0];

endmodule

// File: rtl/bfp_scaler.sv
// bfp_scaler -- consumer side of BFP width tracking. Latches the previous
// stage's max bit width at stage_start, turns it into a shift, applies the
// shift to every complex sample of the stage and accumulates the block exponent.
// Build option: BFP_ROUND_EN (round-half-up instead of truncation).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stage_start, max_bw  start a stage of 2**FFT_N samples with this width
//   bw_clr               1-cycle clear pulse to the max-width tracker
//   exp_clr              clear the exponent accumulator (new frame)
//   in_valid/in_ready, in_re/in_im      sample input handshake
//   out_valid/out_ready, out_re/out_im  scaled sample output handshake
//   shift_amt, exp_acc   shift in force, accumulated block exponent
//   stage_done           1-cycle pulse once a stage has fully left the pipeline
//   err                  sticky: stage_start seen outside IDLE
module bfp_scaler
  import bfp_pkg::*;
#(
  parameter int FFT_DW    = 16,
  parameter int FFT_BFPDW = 5,
  parameter int FFT_N     = 10,
  parameter int EXP_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stage_start,
  input  logic [FFT_BFPDW-1:0] max_bw,
  output logic                 bw_clr,
  input  logic                 exp_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FFT_DW-1:0]    in_re,
  input  logic [FFT_DW-1:0]    in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FFT_DW-1:0]    out_re,
  output logic [FFT_DW-1:0]    out_im,
  output logic [FFT_BFPDW-1:0] shift_amt,
  output logic [EXP_W-1:0]     exp_acc,
  output logic                 stage_done,
  output logic                 err
);

  localparam logic [FFT_N-1:0] CNT_LAST = '1;
  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, {EXP_W{1'b1}}};

  state_t state_reg, state_next;
  logic [FFT_N-1:0] cnt_reg, cnt_next;
  logic [FFT_BFPDW-1:0] shift_reg, shift_new;
  logic [EXP_W-1:0] exp_reg, exp_base;
  logic [EXP_W:0] exp_sum;
  logic err_reg;

  // Two-stage pipeline; index 0 = re, 1 = im.
  logic v1_reg, v2_reg;
  logic [1:0][FFT_DW-1:0] din, d1_reg, d2_reg, sh;
  logic adv1, adv2, accept, start_ok;

  // A stage may load when it is empty or its content moves on this cycle.
  assign adv2   = !v2_reg || out_ready;
  assign adv1   = !v1_reg || adv2;
  assign accept = in_valid && in_ready;
  assign din    = {in_im, in_re};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      bfp_round_shift #(
        .DW(FFT_DW),
        .SW(FFT_BFPDW)
      ) u_shift (
        .din  (d1_reg[gi]),
        .shift(shift_reg),
        .dout (sh[gi])
      );
    end
  endgenerate

  assign shift_new = FFT_BFPDW'(calc_shift(int'(max_bw), FFT_DW));
  assign start_ok  = stage_start && (state_reg == IDLE);
  assign exp_base  = exp_clr ? '0 : exp_reg;
  assign exp_sum   = {1'b0, exp_base} + (EXP_W+1)'(shift_new);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bw_clr     = 1'b0;
    stage_done = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stage_start) begin
          bw_clr     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        in_ready = adv1;
        if (in_valid && adv1) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!v1_reg && !v2_reg) begin
          stage_done = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      exp_reg   <= '0;
      err_reg   <= 1'b0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      d1_reg    <= '0;
      d2_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (start_ok) begin
        shift_reg <= shift_new;
        exp_reg   <= (exp_sum > EXP_MAX) ? EXP_MAX[EXP_W-1:0] : exp_sum[EXP_W-1:0];
      end else if (exp_clr) begin
        exp_reg <= '0;
      end

      if (stage_start && state_reg != IDLE) begin
        err_reg <= 1'b1;
      end

      if (adv1) begin
        v1_reg <= accept;
        if (accept) begin
          d1_reg <= din;
        end
      end
      if (adv2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          d2_reg <= sh;
        end
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_re    = d2_reg[0];
  assign out_im    = d2_reg[1];
  assign shift_amt = shift_reg;
  assign exp_acc   = exp_reg;
  assign err       = err_reg;

endmodule
